// File: rtl/alu_pkg.sv
// Opcode and state definitions shared by the sequential ALU and its multiplier.
package alu_pkg;

    localparam logic M_MISC  = 1'b0;
    localparam logic M_ARITH = 1'b1;

    localparam logic [3:0] S_PASS_A = 4'b1100;
    localparam logic [3:0] S_ADD    = 4'b1001;
    localparam logic [3:0] S_ADC    = 4'b0001;
    localparam logic [3:0] S_SUB    = 4'b0110;
    localparam logic [3:0] S_SBB    = 4'b0010;
    localparam logic [3:0] S_AND    = 4'b1011;
    localparam logic [3:0] S_OR     = 4'b0011;
    localparam logic [3:0] S_XOR    = 4'b0111;
    localparam logic [3:0] S_NOTB   = 4'b0101;
    localparam logic [3:0] S_PASS_B = 4'b1010;
    localparam logic [3:0] S_PASS_B2 = 4'b0100;
    localparam logic [3:0] S_SHL    = 4'b1000;
    localparam logic [3:0] S_SHR    = 4'b1101;
    localparam logic [3:0] S_MUL    = 4'b1110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Op-issue and result bus between the control unit (master) and the ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             m;
    logic [3:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flag_clr;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] hi;
    logic             out_valid;
    logic             cf;
    logic             zf;
    logic             nf;

    modport master (
        output in_valid, m, s, a, b, flag_clr,
        input  in_ready, t, hi, out_valid, cf, zf, nf
    );

    modport slave (
        input  in_valid, m, s, a, b, flag_clr,
        output in_ready, t, hi, out_valid, cf, zf, nf
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc_next;

    // prod is the accumulator after the current step; it is final when done is high.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign prod     = acc_next;
    assign done     = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CNT_W'(WIDTH);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent CF/ZF/NF flags, single-cycle ops and a multi-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    state_t             state;
    logic [WIDTH-1:0]   t_r;
    logic [WIDTH-1:0]   hi_r;
    logic               ov_r;
    logic               cf_r;
    logic               zf_r;
    logic               nf_r;

    logic               in_ready;
    logic               accept;
    logic [WIDTH-1:0]   nx_t;
    logic               nx_cf;
    logic               nx_zf;
    logic               nx_nf;
    logic [WIDTH:0]     sum;
    logic               is_mul;
    logic               is_arith;
    logic               zn_from_t;

    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;

    assign in_ready = (state == ST_IDLE) && !mul_busy;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.t         = t_r;
    assign bus.hi        = hi_r;
    assign bus.out_valid = ov_r;
    assign bus.cf        = cf_r;
    assign bus.zf        = zf_r;
    assign bus.nf        = nf_r;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_mul),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (prod)
    );

    // Single-cycle result and flags; undefined codes fall through with t=0 and flags held.
    always_comb begin
        nx_t      = '0;
        nx_cf     = cf_r;
        nx_zf     = zf_r;
        nx_nf     = nf_r;
        sum       = '0;
        is_mul    = 1'b0;
        is_arith  = 1'b0;
        zn_from_t = 1'b0;
        if (bus.m == M_MISC) begin
            if (bus.s == S_PASS_A) begin
                nx_t      = bus.a;
                zn_from_t = 1'b1;
            end
        end else begin
            case (bus.s)
                S_ADD: begin
                    sum      = {1'b0, bus.a} + {1'b0, bus.b};
                    is_arith = 1'b1;
                end
                S_ADC: begin
                    sum      = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(cf_r);
                    is_arith = 1'b1;
                end
                S_SUB: begin
                    sum      = {1'b0, bus.b} - {1'b0, bus.a};
                    is_arith = 1'b1;
                end
                S_SBB: begin
                    sum      = {1'b0, bus.b} - {1'b0, bus.a} - (WIDTH+1)'(cf_r);
                    is_arith = 1'b1;
                end
                S_AND: begin
                    nx_t      = bus.a & bus.b;
                    zn_from_t = 1'b1;
                end
                S_OR: begin
                    nx_t      = bus.a | bus.b;
                    zn_from_t = 1'b1;
                end
                S_XOR: begin
                    nx_t      = bus.a ^ bus.b;
                    zn_from_t = 1'b1;
                end
                S_NOTB: begin
                    nx_t      = ~bus.b;
                    zn_from_t = 1'b1;
                end
                S_PASS_B, S_PASS_B2: begin
                    nx_t      = bus.b;
                    zn_from_t = 1'b1;
                end
                S_SHL: begin
                    nx_t      = {bus.a[WIDTH-2:0], 1'b0};
                    nx_cf     = bus.a[WIDTH-1];
                    zn_from_t = 1'b1;
                end
                S_SHR: begin
                    nx_t      = {1'b0, bus.a[WIDTH-1:1]};
                    nx_cf     = bus.a[0];
                    zn_from_t = 1'b1;
                end
                S_MUL: is_mul = 1'b1;
                default: ;
            endcase
        end
        // The carry bit sits above t, so zf/nf from t never see it.
        if (is_arith) begin
            nx_t      = sum[WIDTH-1:0];
            nx_cf     = sum[WIDTH];
            zn_from_t = 1'b1;
        end
        if (zn_from_t) begin
            nx_zf = (nx_t == '0);
            nx_nf = nx_t[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            t_r   <= '0;
            hi_r  <= '0;
            ov_r  <= 1'b0;
            cf_r  <= 1'b0;
            zf_r  <= 1'b0;
            nf_r  <= 1'b0;
        end else begin
            ov_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && !is_mul) begin
                        t_r  <= nx_t;
                        hi_r <= '0;
                        ov_r <= 1'b1;
                        cf_r <= nx_cf;
                        zf_r <= nx_zf;
                        nf_r <= nx_nf;
                    end else begin
                        if (accept) begin
                            state <= ST_MUL;
                        end
                        if (bus.flag_clr) begin
                            cf_r <= 1'b0;
                            zf_r <= 1'b0;
                            nf_r <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    // A retiring product's flags take priority over flag_clr.
                    if (mul_done) begin
                        t_r   <= prod[WIDTH-1:0];
                        hi_r  <= prod[2*WIDTH-1:WIDTH];
                        ov_r  <= 1'b1;
                        cf_r  <= (prod[2*WIDTH-1:WIDTH] != '0);
                        zf_r  <= (prod == '0);
                        nf_r  <= prod[2*WIDTH-1];
                        state <= ST_IDLE;
                    end else if (bus.flag_clr) begin
                        cf_r <= 1'b0;
                        zf_r <= 1'b0;
                        nf_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
